// File: rtl/fifo_egress_scheduler_pkg.sv
// Shared types and helpers for the switch egress scheduler and its arbiters.
package switch_scheduler_package;

    typedef enum logic {
        IDLE,
        TRANSFER
    } scheduler_state_t;

    // Index width for n requesters; never collapses to zero bits.
    function automatic int port_index_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_egress_scheduler_if.sv
// Ingress FIFO heads on one side, egress valid/ready stream on the other.
interface fifo_egress_scheduler_if
    import switch_scheduler_package::*;
#(
    parameter int NUMBER_OF_PORTS = 4,
    parameter int DATA_WIDTH      = 16
);
    localparam int IW = port_index_width(NUMBER_OF_PORTS);

    logic [NUMBER_OF_PORTS-1:0]            port_enable;
    logic [NUMBER_OF_PORTS*DATA_WIDTH-1:0] fifo_read_data;
    logic [NUMBER_OF_PORTS-1:0]            fifo_read_data_valid;
    logic [NUMBER_OF_PORTS-1:0]            fifo_read_enable;
    logic [DATA_WIDTH-1:0]                 output_data;
    logic                                  output_valid;
    logic                                  output_ready;
    logic [IW-1:0]                         output_source;
    logic                                  busy;
    logic                                  packet_done;

    modport master (
        input  port_enable, fifo_read_data, fifo_read_data_valid, output_ready,
        output fifo_read_enable, output_data, output_valid, output_source, busy, packet_done
    );

    modport slave (
        output port_enable, fifo_read_data, fifo_read_data_valid, output_ready,
        input  fifo_read_enable, output_data, output_valid, output_source, busy, packet_done
    );
endinterface

// File: rtl/fifo_egress_scheduler_picker.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
module round_robin_priority_picker
    import switch_scheduler_package::*;
#(
    parameter int NUMBER_OF_PORTS = 4,
    localparam int IW = port_index_width(NUMBER_OF_PORTS)
) (
    input  logic [NUMBER_OF_PORTS-1:0] request_i,
    input  logic [IW-1:0]              start_i,
    output logic [IW-1:0]              grant_o,
    output logic                       any_request_o
);
    always_comb begin
        grant_o       = '0;
        any_request_o = 1'b0;
        // Walk offsets high to low so the smallest offset from start wins.
        for (int i = NUMBER_OF_PORTS - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(start_i) + i) % NUMBER_OF_PORTS;
            if (request_i[idx]) begin
                grant_o       = IW'(idx);
                any_request_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_egress_scheduler.sv
// Packet-aware round-robin drain of per-port FWFT FIFOs into one registered egress stream.
module fifo_egress_scheduler
    import switch_scheduler_package::*;
#(
    parameter int NUMBER_OF_PORTS = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int LAST_BIT_INDEX  = DATA_WIDTH - 1,
    localparam int IW = port_index_width(NUMBER_OF_PORTS)
) (
    input logic                     clock,
    input logic                     reset,
    fifo_egress_scheduler_if.master bus
);
    scheduler_state_t      state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [IW-1:0]         source_q;

    logic [NUMBER_OF_PORTS-1:0] candidates;
    logic [IW-1:0]              pick;
    logic                       pick_any;
    logic [DATA_WIDTH-1:0]      head;
    logic                       load_ok;
    logic                       pop;
    logic                       last_word;

    assign candidates = bus.fifo_read_data_valid & bus.port_enable;

    round_robin_priority_picker #(.NUMBER_OF_PORTS(NUMBER_OF_PORTS)) u_picker (
        .request_i     (candidates),
        .start_i       (rr_q),
        .grant_o       (pick),
        .any_request_o (pick_any)
    );

    assign head      = bus.fifo_read_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign load_ok   = !valid_q || bus.output_ready;
    // Gated by reset so an abandoned packet loses no word in the reset cycle.
    assign pop       = !reset && (state_q == TRANSFER) && bus.fifo_read_data_valid[grant_q] && load_ok;
    assign last_word = head[LAST_BIT_INDEX];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        bus.fifo_read_enable = '0;
        bus.fifo_read_enable[grant_q] = pop;
        bus.packet_done = pop && last_word;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (pop && last_word) begin
                    rr_d    = (int'(grant_q) == NUMBER_OF_PORTS - 1) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            source_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            if (pop) begin
                data_q   <= head;
                valid_q  <= 1'b1;
                source_q <= grant_q;
            end else if (bus.output_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.output_data   = data_q;
    assign bus.output_valid  = valid_q;
    assign bus.output_source = source_q;
    assign bus.busy          = (state_q == TRANSFER);
endmodule

// File: tb/tb_fifo_egress_scheduler.sv
// Directed bench: FWFT FIFO models feed the scheduler; egress words are scoreboarded.
module tb_fifo_egress_scheduler;
    localparam int NP = 4;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fifo_egress_scheduler_if #(.NUMBER_OF_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    fifo_egress_scheduler #(.NUMBER_OF_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          ready;
        logic [NP-1:0] ren;
        logic          vld;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t         tbl[6];
    logic [DW-1:0] fq[NP][$];
    logic [19:0]  got_q[$];
    int checks = 0;
    int errors = 0;
    int dones  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_heads();
        for (int i = 0; i < NP; i++) begin
            bus.fifo_read_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
            bus.fifo_read_data_valid[i]    = (fq[i].size() > 0);
        end
    endtask

    // Sample before the edge, advance one clock, then apply FIFO pops.
    task automatic tick();
        logic [NP-1:0] ren;
        #1;
        ren = bus.fifo_read_enable;
        if ($countones(ren) > 1) chk("onehot_ren", 32'(ren), 32'(ren & -ren));
        if (bus.output_valid && bus.output_ready)
            got_q.push_back({2'b00, bus.output_source, bus.output_data});
        if (bus.packet_done) dones++;
        @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++) if (ren[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        update_heads();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NP; i++) fq[i].delete();
        update_heads();
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        dones = 0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() > 0 || bus.output_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 32'(n), 32'(0));
    endtask

    function automatic logic [DW-1:0] w(input int last, input int p, input int k, input int j);
        return DW'((last << 15) | (p << 8) | (k << 4) | j);
    endfunction

    initial begin
        tbl[0] = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'b0001, 1'b1, 16'h0011, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'b0001, 1'b1, 16'h0022, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 4'b0000, 1'b1, 16'h8033, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'b0000, 1'b0, 16'h8033, 1'b0, 1'b0};

        bus.port_enable  = 4'hF;
        bus.output_ready = 1'b1;
        bus.fifo_read_data = '0;
        bus.fifo_read_data_valid = '0;

        // Reset state, with a non-empty FIFO present to prove no pop under reset.
        reset = 1'b1;
        fq[0].push_back(16'h1234);
        update_heads();
        tick();
        #1;
        chk("rst_valid", 32'(bus.output_valid), 0);
        chk("rst_data", 32'(bus.output_data), 0);
        chk("rst_src", 32'(bus.output_source), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.packet_done), 0);
        chk("rst_ren", 32'(bus.fifo_read_enable), 0);

        // Single port, cycle-accurate table.
        do_reset();
        fq[0] = '{16'h0011, 16'h0022, 16'h8033};
        update_heads();
        for (int r = 0; r < 6; r++) begin
            bus.output_ready = tbl[r].ready;
            #1;
            chk($sformatf("single_ren[%0d]", r), 32'(bus.fifo_read_enable), 32'(tbl[r].ren));
            chk($sformatf("single_vld[%0d]", r), 32'(bus.output_valid), 32'(tbl[r].vld));
            chk($sformatf("single_data[%0d]", r), 32'(bus.output_data), 32'(tbl[r].data));
            chk($sformatf("single_src[%0d]", r), 32'(bus.output_source), 0);
            chk($sformatf("single_busy[%0d]", r), 32'(bus.busy), 32'(tbl[r].busy));
            chk($sformatf("single_done[%0d]", r), 32'(bus.packet_done), 32'(tbl[r].done));
            tick();
        end

        // Fairness: two 2-word packets per port, expect 0,1,2,3,0,1,2,3 without interleave.
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) begin
                fq[p].push_back(w(0, p, k, 0));
                fq[p].push_back(w(1, p, k, 1));
            end
        update_heads();
        drain(200, "fair");
        chk("fair_count", 32'(got_q.size()), 16);
        chk("fair_dones", 32'(dones), 8);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            int k, p, j;
            k = i / 8; p = (i / 2) % 4; j = i % 2;
            chk($sformatf("fair_word[%0d]", i), 32'(got_q[i]), 32'({4'(p), w(j, p, k, j)}));
        end

        // Back-pressure mid-packet on port 2.
        do_reset();
        for (int j = 0; j < 4; j++) fq[2].push_back(w(j == 3, 2, 0, j));
        update_heads();
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 20) begin tick(); n++; end
            chk("bp_start", 32'(got_q.size()), 1);
        end
        bus.output_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_vld[%0d]", c), 32'(bus.output_valid), 1);
            chk($sformatf("bp_data[%0d]", c), 32'(bus.output_data), 32'(w(0, 2, 0, 1)));
            chk($sformatf("bp_ren[%0d]", c), 32'(bus.fifo_read_enable), 0);
            tick();
        end
        bus.output_ready = 1'b1;
        drain(50, "bp");
        chk("bp_count", 32'(got_q.size()), 4);
        for (int j = 0; j < 4 && j < got_q.size(); j++)
            chk($sformatf("bp_word[%0d]", j), 32'(got_q[j]), 32'({4'd2, w(j == 3, 2, 0, j)}));

        // Mask 1010: only ports 1 and 3, alternating.
        do_reset();
        bus.port_enable = 4'b1010;
        for (int p = 0; p < NP; p++) begin
            fq[p].push_back(w(1, p, 0, 0));
            fq[p].push_back(w(1, p, 1, 0));
        end
        update_heads();
        for (int c = 0; c < 30; c++) tick();
        chk("mask_count", 32'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk($sformatf("mask_src[%0d]", i), 32'(got_q[i][19:16]), (i % 2 == 0) ? 1 : 3);
        chk("mask_p0_left", 32'(fq[0].size()), 2);
        chk("mask_p2_left", 32'(fq[2].size()), 2);

        // Mask change mid-packet: port 0 finishes, then is skipped.
        do_reset();
        bus.port_enable = 4'hF;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) fq[0].push_back(w(j == 2, 0, k, j));
        for (int j = 0; j < 3; j++) fq[1].push_back(w(j == 2, 1, 0, j));
        update_heads();
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 20) begin tick(); n++; end
        end
        bus.port_enable = 4'b1110;
        for (int c = 0; c < 30; c++) tick();
        chk("mchg_count", 32'(got_q.size()), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            chk($sformatf("mchg_src[%0d]", i), 32'(got_q[i][19:16]), (i < 3) ? 0 : 1);
        chk("mchg_p0_left", 32'(fq[0].size()), 3);

        // Reset mid-packet after rr has moved to 2.
        do_reset();
        bus.port_enable = 4'hF;
        fq[1].push_back(w(1, 1, 0, 0));
        update_heads();
        drain(20, "rr_pre");
        for (int j = 0; j < 3; j++) fq[2].push_back(w(j == 2, 2, 0, j));
        update_heads();
        begin
            int n = 0;
            while (!bus.output_valid && n < 20) begin tick(); n++; end
            chk("rstm_started", 32'(bus.output_valid), 1);
        end
        reset = 1'b1;
        #1;
        chk("rstm_ren", 32'(bus.fifo_read_enable), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rstm_vld", 32'(bus.output_valid), 0);
        chk("rstm_busy", 32'(bus.busy), 0);
        chk("rstm_p2_left", 32'(fq[2].size()), 2);
        got_q.delete();
        fq[0].push_back(w(1, 0, 5, 0));
        fq[3].push_back(w(1, 3, 5, 0));
        update_heads();
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 20) begin tick(); n++; end
        end
        chk("rstm_first", 32'(got_q.size() > 0 ? got_q[0] : 20'hFFFFF), 32'({4'd0, w(1, 0, 5, 0)}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
